// File: rtl/scalar_regfile_banked.sv
// scalar_regfile_banked: banked scalar RF, per-bank RR read arbitration with coalescing; SRF_BYPASS_EN adds same-cycle write forwarding
module dualportSRAM #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH = 6
) (
  input  logic                clk,
  input  logic                wen,
  input  logic [DEPTH-1:0]    waddr,
  input  logic [BITWIDTH-1:0] wdata,
  input  logic [BITWIDTH-1:0] wmask,
  input  logic                ren,
  input  logic [DEPTH-1:0]    raddr,
  output logic [BITWIDTH-1:0] q
);
  logic [BITWIDTH-1:0] mem [2**DEPTH];
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    if (ren) q <= mem[raddr];
  end
endmodule

module scalar_regfile_banked #(
  parameter int XLEN = 32,
  parameter int NUM_BANK = 4,
  parameter int BANK_DEPTH = 64,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = $clog2(NUM_BANK*BANK_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_req_valid_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_req_addr_i,
  output logic [NUM_RD-1:0]        rd_req_ready_o,
  output logic [NUM_RD-1:0]        rd_rsp_valid_o,
  output logic [NUM_RD*XLEN-1:0]   rd_rsp_data_o,
  input  logic                     wr_valid_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [XLEN-1:0]          wr_data_i
);
  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int ROW_W = $clog2(BANK_DEPTH);
  localparam int RD_W = NUM_RD > 1 ? $clog2(NUM_RD) : 1;
  logic [NUM_RD-1:0] vld, gnt, rsp_vld;
  logic [ADDR_W-1:0] ch_addr [NUM_RD];
  logic [BANK_W-1:0] rsp_bank [NUM_RD];
  logic [RD_W-1:0] rr_ptr [NUM_BANK];
  logic [RD_W-1:0] win [NUM_BANK];
  logic [NUM_BANK-1:0] busy;
  logic [ROW_W-1:0] rd_row [NUM_BANK];
  logic [XLEN-1:0] q [NUM_BANK];
  int c;
  assign vld = rd_req_valid_i & {NUM_RD{rst_n}};
  assign rd_req_ready_o = gnt;
  assign rd_rsp_valid_o = rsp_vld;
  // first valid channel from rr_ptr wins; same-address channels ride along
  always_comb begin
    gnt = '0;
    busy = '0;
    c = 0;
    for (int b = 0; b < NUM_BANK; b++) begin
      win[b] = '0;
      for (int i = 0; i < NUM_RD; i++) begin
        c = (int'(rr_ptr[b]) + i) % NUM_RD;
        if (!busy[b] && vld[c] && ch_addr[c][BANK_W-1:0] == BANK_W'(b)) begin
          busy[b] = 1'b1;
          win[b] = RD_W'(c);
        end
      end
      rd_row[b] = ch_addr[win[b]][ADDR_W-1:BANK_W];
      for (int k = 0; k < NUM_RD; k++)
        if (busy[b] && vld[k] && ch_addr[k] == ch_addr[win[b]]) gnt[k] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld <= '0;
      for (int b = 0; b < NUM_BANK; b++) rr_ptr[b] <= '0;
      for (int k = 0; k < NUM_RD; k++) rsp_bank[k] <= '0;
    end else begin
      rsp_vld <= gnt;
      for (int b = 0; b < NUM_BANK; b++)
        if (busy[b]) rr_ptr[b] <= RD_W'((int'(win[b]) + 1) % NUM_RD);
      for (int k = 0; k < NUM_RD; k++)
        if (gnt[k]) rsp_bank[k] <= ch_addr[k][BANK_W-1:0];
    end
  end
`ifdef SRF_BYPASS_EN
  logic [NUM_RD-1:0] byp_hit;
  logic [XLEN-1:0] byp_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit <= '0;
      byp_data <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++)
        byp_hit[k] <= gnt[k] && wr_valid_i && wr_addr_i == ch_addr[k];
      byp_data <= wr_data_i;
    end
  end
`endif
  genvar k, b;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_ch
      assign ch_addr[k] = rd_req_addr_i[k*ADDR_W +: ADDR_W];
`ifdef SRF_BYPASS_EN
      assign rd_rsp_data_o[k*XLEN +: XLEN] = !rsp_vld[k] ? '0 : byp_hit[k] ? byp_data : q[rsp_bank[k]];
`else
      assign rd_rsp_data_o[k*XLEN +: XLEN] = rsp_vld[k] ? q[rsp_bank[k]] : '0;
`endif
    end
    for (b = 0; b < NUM_BANK; b++) begin : g_bank
      dualportSRAM #(.BITWIDTH(XLEN), .DEPTH(ROW_W)) u_sram (
        .clk   (clk),
        .wen   (wr_valid_i && wr_addr_i[BANK_W-1:0] == BANK_W'(b)),
        .waddr (wr_addr_i[ADDR_W-1:BANK_W]),
        .wdata (wr_data_i),
        .wmask ({XLEN{1'b1}}),
        .ren   (busy[b]),
        .raddr (rd_row[b]),
        .q     (q[b])
      );
    end
  endgenerate
endmodule

// File: doc/scalar_regfile_banked.md
# scalar_regfile_banked

Parametrised multi-bank, multi-read-port scalar register file for the SM operand collector. It supersedes the single-bank scalar register bank. Each read channel has a valid/ready handshake, and per-bank round-robin arbitration resolves bank conflicts. Identical-address reads are coalesced, and optional write-to-read forwarding is available. It sits between the operand collector's scalar request units and the writeback arbiter.

## Interface
Parameters:
- `XLEN`, default 32, data width.
- `NUM_BANK`, default 4, number of banks; power of two, ≥2.
- `BANK_DEPTH`, default 64, rows per bank; power of two.
- `NUM_RD`, default 2, number of read channels; 1..4.
- `ADDR_W`, default `$clog2(NUM_BANK*BANK_DEPTH)`, register index width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd_req_valid_i` in `NUM_RD`: per-channel read request.
- `rd_req_addr_i` in `NUM_RD*ADDR_W`: per-channel register index; channel k occupies bits `[k*ADDR_W +: ADDR_W]`.
- `rd_req_ready_o` out `NUM_RD`: request accepted this cycle.
- `rd_rsp_valid_o` out `NUM_RD`: read data valid.
- `rd_rsp_data_o` out `NUM_RD*XLEN`: per-channel read data.
- `wr_valid_i` in 1: write enable; writes are always accepted.
- `wr_addr_i` in `ADDR_W`: write index.
- `wr_data_i` in `XLEN`: write data.

## Operation
- Address split:
  - bank = `addr[$clog2(NUM_BANK)-1:0]`
  - row = `addr[ADDR_W-1:$clog2(NUM_BANK)]`
- Storage: one `dualportSRAM` instance per bank (`BITWIDTH=XLEN`, `DEPTH=$clog2(BANK_DEPTH)`), with 1-cycle synchronous read and all write-mask bits enabled. Contents are not reset.
- Arbitration per bank, each cycle:
  - Among valid channels targeting the bank, pick a winner by round-robin starting at `rr_ptr[bank]`.
  - Grant the winner, plus every other valid channel whose full address equals the winner's (coalescing).
  - `rd_req_ready_o[k]=1` iff channel k is granted. Ready is combinational from valid and address.
- `rr_ptr[bank]`:
  - Resets to 0.
  - On any grant in that bank, it moves to (winner+1) mod `NUM_RD`.
  - It holds when the bank is idle.
- Ungranted channels keep valid and address stable; the block holds no request storage.
- A bank's SRAM read enable is asserted only when that bank grants.
- Each channel's response mux uses a registered bank select, with `rd_rsp_data_o[k]` taken from the granted bank's SRAM Q.
- `rd_rsp_data_o[k]` is forced to 0 whenever `rd_rsp_valid_o[k]=0`.
- There is no response backpressure; the consumer must take the data in the valid cycle.
- Write: when `wr_valid_i=1`, write `wr_data_i` to bank/row of `wr_addr_i`. Writes never stall reads. There is one write per cycle.

## Timing
- Reset values: `rd_rsp_valid_o=0`, `rd_rsp_data_o=0`, all `rr_ptr=0`. `rd_req_ready_o` is 0 while `rst_n=0`.
- Read latency is 1 cycle: a grant in cycle T gives `rd_rsp_valid_o[k]=1` in T+1, for exactly one cycle per grant.
- Back-to-back grants on a channel produce back-to-back responses.
- Write visibility:
  - A write in cycle T-1 or earlier is always visible to a read granted in cycle T.
  - A write in the same cycle T to the same address is covered under Configuration.
- Worst-case conflict wait for a persistently valid channel is `NUM_RD-1` cycles (round-robin fairness).
- Reset asserted mid-operation: in-flight responses are dropped, and `rd_rsp_valid_o` goes to 0 immediately (asynchronously).
- Simultaneous events:
  - Grants to different banks proceed in parallel.
  - Coalesced channels receive identical data in the same cycle.

## Configuration
- `SRF_BYPASS_EN` defined:
  - Register the grant-cycle compare (`wr_valid_i` && `wr_addr_i`==granted addr) and `wr_data_i`.
  - In T+1, the response returns the registered write data instead of SRAM Q.
  - Result: a same-cycle write is visible (read-after-write, 0 cycles).
- `SRF_BYPASS_EN` undefined:
  - No forwarding logic.
  - A read granted in the same cycle as a write to the same address returns the pre-write value; the write is visible from the next grant on.

## Test plan
- Reset: hold `rst_n=0`, drive requests → all `rd_rsp_valid_o=0`, data=0, ready=0. Release, write addr 5=0x1234 in cycle 0, read addr 5 on ch0 in cycle 1 → ch0 valid with 0x1234 in cycle 2.
- Bank conflict: preload addr 4=0xA, addr 8=0xB (both bank 0); hold ch0=4 and ch1=8 valid for 3 cycles.
  - Grants: ch0, then ch1, then ch0.
  - Responses: 0xA, 0xB, 0xA, each one cycle after its grant.
- Coalescing: ch0=ch1=addr 12 (=0x55) in one cycle → both ready=1, and both responses 0x55 in the next cycle. `rr_ptr[0]` advances to 1.
- Parallel banks: ch0=addr 1 (=0x11), ch1=addr 2 (=0x22) in the same cycle → both granted; responses 0x11/0x22 in the same cycle.
- Same-cycle write/read: addr 3 holds 0x7; in one cycle write 0x9 to addr 3 and read addr 3.
  - With `SRF_BYPASS_EN`, the response is 0x9.
  - Without it, the response is 0x7, and the next read returns 0x9.
- Reset mid-flight: grant a read in cycle T, assert `rst_n=0` in T+1 before the clock edge → `rd_rsp_valid_o=0` immediately and no response is produced after release.
